multi_cycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the CPU datapath. It takes the per-instruction decode outputs of the general controller and steps them through FETCH, DECODE, EXEC, MEM and WB.
- It drives the enables for a single shared instruction/data memory with a ready handshake, plus the PC, IR and register-file write strobes.
- It counts retired instructions and detects HALT and memory timeout.

---
 rtl/multi_cycle_ctrl_pkg.sv | 31 +++
 rtl/multi_cycle_ctrl_if.sv | 11 +
 rtl/multi_cycle_ctrl_mem_wait_timer.sv | 32 +++
 rtl/multi_cycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// PC / write-back source codes and the HALT opcode.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // A state is "busy" whenever the sequencer is actively stepping an instruction.
    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_HALT) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Shared instruction/data memory handshake between the sequencer (master)
// and the memory (slave).
interface multi_cycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// Counts memory wait cycles for the access in progress and flags a timeout
// when the count reaches MEM_TIMEOUT with the memory still not ready.
// The count is zero whenever no access is pending, so every entry to an
// access state starts from zero.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] wait_cnt;

    // Advance while an access is stalled; drop back to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (active && !mem_ready) begin
            wait_cnt <= wait_cnt + W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && active && !mem_ready &&
                     (wait_cnt == W'(MEM_TIMEOUT));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer: steps each decoded instruction through
// FETCH / DECODE / EXEC / MEM / WB, drives the shared memory handshake and
// the PC / IR / register-file strobes, and counts retired instructions.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic               dec_RegWr,
    input  logic               dec_MemToReg,
    input  logic               dec_MemWr,
    input  logic               dec_Branch,
    input  logic               dec_Jump,
    input  logic               dec_Link,
    input  logic               dec_nop,
    input  logic               alu_zero,
    multi_cycle_ctrl_if.master mem,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic               retired,
    output logic [CNT_W-1:0]   instr_count,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    state_t state;
    logic   mem_active;
    logic   timeout;

    assign mem_active = (state == ST_FETCH) || (state == ST_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (mem_active),
        .mem_ready (mem.mem_ready),
        .expired   (timeout)
    );

    // Sequencer state transitions; a ready memory always beats a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem.mem_ready)  state <= ST_DECODE;
                    else if (timeout)   state <= ST_ERROR;
                end
                ST_DECODE: begin
                    if (opcode == HALT_OPCODE)  state <= ST_HALT;
                    else if (dec_nop)           state <= ST_FETCH;
                    else if (dec_Jump)          state <= ST_FETCH;
                    else                        state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_Branch)                     state <= ST_FETCH;
                    else if (dec_MemWr || dec_MemToReg) state <= ST_MEM;
                    else                                state <= ST_WB;
                end
                ST_MEM: begin
                    if (mem.mem_ready)  state <= dec_MemWr ? ST_FETCH : ST_WB;
                    else if (timeout)   state <= ST_ERROR;
                end
                ST_WB:    state <= ST_FETCH;
                ST_HALT:  state <= ST_HALT;
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_ERROR;
            endcase
        end
    end

    // Strobes decoded from the current state and same-cycle inputs.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.mem_sel = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SRC_SEQ;
        reg_we      = 1'b0;
        wb_sel      = WB_SEL_ALU;
        retired     = 1'b0;
        case (state)
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_SEQ;
                end
            end
            ST_DECODE: begin
                if (opcode == HALT_OPCODE) begin
                    retired = 1'b0;
                end else if (dec_nop) begin
                    retired = 1'b1;
                end else if (dec_Jump) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_SRC_JUMP;
                    retired = 1'b1;
                    if (dec_Link) begin
                        reg_we = 1'b1;
                        wb_sel = WB_SEL_LINK;
                    end
                end
            end
            ST_EXEC: begin
                if (dec_Branch) begin
                    pc_we   = alu_zero;
                    pc_src  = PC_SRC_BRANCH;
                    retired = 1'b1;
                end
            end
            ST_MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_sel = 1'b1;
                mem.mem_we  = dec_MemWr;
                if (mem.mem_ready && dec_MemWr) retired = 1'b1;
            end
            ST_WB: begin
                reg_we  = dec_RegWr;
                wb_sel  = dec_MemToReg ? WB_SEL_MEM : WB_SEL_ALU;
                retired = 1'b1;
            end
            default: begin
                retired = 1'b0;
            end
        endcase
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retired) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign busy   = is_busy(state);
    assign halted = (state == ST_HALT);
    assign err    = (state == ST_ERROR);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: reset checks, a table of directed
// instructions, randomized instructions against a per-instruction trace
// model, then timeout / async reset and HALT sequences.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    typedef enum int {I_RTYPE, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_NOP} iclass_t;

    typedef struct {
        iclass_t    cls;
        logic       zero;
        int         fetchWait;
        int         memWait;
        int         expCycles;
        int         expPcWe;
        int         expRegWe;
        logic [1:0] expWbSel;
        int         expMemCycles;
        int         expMemWe;
    } vec_t;

    typedef struct {
        logic        ready;
        logic [11:0] exp;
    } step_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [5:0]       opcode;
    logic             dec_RegWr, dec_MemToReg, dec_MemWr, dec_Branch;
    logic             dec_Jump, dec_Link, dec_nop, alu_zero;
    logic             ir_we, pc_we, reg_we, retired, busy, halted, err;
    logic [1:0]       pc_src, wb_sel;
    logic [CNT_W-1:0] instr_count;

    int               compared   = 0;
    int               mismatched = 0;
    logic [CNT_W-1:0] modelCount = '0;
    vec_t             tbl[10];
    step_t            trace[$];

    multi_cycle_ctrl_if bus();

    multi_cycle_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .dec_RegWr    (dec_RegWr),
        .dec_MemToReg (dec_MemToReg),
        .dec_MemWr    (dec_MemWr),
        .dec_Branch   (dec_Branch),
        .dec_Jump     (dec_Jump),
        .dec_Link     (dec_Link),
        .dec_nop      (dec_nop),
        .alu_zero     (alu_zero),
        .mem          (bus.master),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .retired      (retired),
        .instr_count  (instr_count),
        .busy         (busy),
        .halted       (halted),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obsVec();
        return {bus.mem_req, bus.mem_we, bus.mem_sel, ir_we, pc_we, pc_src,
                reg_we, wb_sel, retired, busy};
    endfunction

    function automatic logic [11:0] mk(input logic req, input logic we, input logic sel,
                                       input logic ir, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] wbs, input logic ret);
        return {req, we, sel, ir, pcw, pcs, rw, wbs, ret, 1'b1};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setDecode(input iclass_t cls, input logic zero);
        dec_RegWr    = (cls == I_RTYPE) || (cls == I_LW);
        dec_MemToReg = (cls == I_LW);
        dec_MemWr    = (cls == I_SW);
        dec_Branch   = (cls == I_BEQ);
        dec_Jump     = (cls == I_J) || (cls == I_JAL);
        dec_Link     = (cls == I_JAL);
        dec_nop      = (cls == I_NOP);
        alu_zero     = zero;
        case (cls)
            I_LW:    opcode = 6'h23;
            I_SW:    opcode = 6'h2b;
            I_BEQ:   opcode = 6'h04;
            I_J:     opcode = 6'h02;
            I_JAL:   opcode = 6'h03;
            default: opcode = 6'h00;
        endcase
    endtask

    // Directed instruction: memory stalls steered by the request the DUT shows,
    // observations summarised and compared against the table entry.
    task automatic applyStimulus(input vec_t v, input int idx);
        int fw = v.fetchWait;
        int mw = v.memWait;
        int cycles = 0, pcw = 0, irc = 0, rw = 0, memc = 0, memwe = 0;
        logic [1:0] wbs = 2'b00;
        logic done = 1'b0;
        setDecode(v.cls, v.zero);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_sel) begin
                bus.mem_ready = (fw == 0);
                if (fw > 0) fw--;
            end else if (bus.mem_req) begin
                bus.mem_ready = (mw == 0);
                if (mw > 0) mw--;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cycles++;
            if (pc_we) pcw++;
            if (ir_we) irc++;
            if (reg_we) begin
                rw++;
                wbs = wb_sel;
            end
            if (bus.mem_req && bus.mem_sel) memc++;
            if (bus.mem_we) memwe++;
            if (retired) done = 1'b1;
        end
        if (!done) checkOutput($sformatf("vec%0d_retire_seen", idx), 0, 1);
        checkOutput($sformatf("vec%0d_cycles", idx), cycles, v.expCycles);
        checkOutput($sformatf("vec%0d_pc_we", idx), pcw, v.expPcWe);
        checkOutput($sformatf("vec%0d_ir_we", idx), irc, 1);
        checkOutput($sformatf("vec%0d_reg_we", idx), rw, v.expRegWe);
        checkOutput($sformatf("vec%0d_wb_sel", idx), wbs, v.expWbSel);
        checkOutput($sformatf("vec%0d_mem_cycles", idx), memc, v.expMemCycles);
        checkOutput($sformatf("vec%0d_mem_we", idx), memwe, v.expMemWe);
        @(posedge clk);
        #1;
        modelCount++;
        checkOutput($sformatf("vec%0d_count", idx), instr_count, modelCount);
    endtask

    // Reference model: the expected per-cycle strobes of one instruction,
    // built from its class and the chosen memory stall lengths.
    task automatic buildTrace(input iclass_t cls, input logic zero, input int fw, input int mw);
        logic store = (cls == I_SW);
        trace.delete();
        for (int i = 0; i < fw; i++) trace.push_back('{1'b0, mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0)});
        trace.push_back('{1'b1, mk(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0)});
        case (cls)
            I_NOP: trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1)});
            I_J:   trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 1)});
            I_JAL: trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 1)});
            default: begin
                trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0)});
                if (cls == I_BEQ) begin
                    trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, zero, 2'b01, 0, 2'b00, 1)});
                end else begin
                    trace.push_back('{1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0)});
                    if (cls != I_RTYPE) begin
                        for (int i = 0; i < mw; i++)
                            trace.push_back('{1'b0, mk(1, store, 1, 0, 0, 2'b00, 0, 2'b00, 0)});
                        trace.push_back('{1'b1, mk(1, store, 1, 0, 0, 2'b00, 0, 2'b00, store)});
                    end
                    if (cls != I_SW)
                        trace.push_back('{1'($urandom_range(0, 1)),
                                          mk(0, 0, 0, 0, 0, 2'b00, 1, (cls == I_LW) ? 2'b01 : 2'b00, 1)});
                end
            end
        endcase
    endtask

    task automatic runModelInstr(input iclass_t cls, input logic zero, input int fw, input int mw);
        step_t s;
        setDecode(cls, zero);
        buildTrace(cls, zero, fw, mw);
        while (trace.size() > 0) begin
            s = trace.pop_front();
            @(negedge clk);
            bus.mem_ready = s.ready;
            #1;
            checkOutput($sformatf("trace_%s", cls.name()), obsVec(), s.exp);
        end
        @(posedge clk);
        #1;
        modelCount++;
        checkOutput("trace_count", instr_count, modelCount);
    endtask

    initial begin
        tbl[0] = '{I_RTYPE, 1'b0, 0, 0, 4, 1, 1, 2'b00, 0, 0};
        tbl[1] = '{I_LW,    1'b0, 0, 3, 8, 1, 1, 2'b01, 4, 0};
        tbl[2] = '{I_BEQ,   1'b1, 0, 0, 3, 2, 0, 2'b00, 0, 0};
        tbl[3] = '{I_BEQ,   1'b0, 0, 0, 3, 1, 0, 2'b00, 0, 0};
        tbl[4] = '{I_JAL,   1'b0, 0, 0, 2, 2, 1, 2'b10, 0, 0};
        tbl[5] = '{I_SW,    1'b0, 2, 1, 7, 1, 0, 2'b00, 2, 2};
        tbl[6] = '{I_J,     1'b0, 1, 0, 3, 2, 0, 2'b00, 0, 0};
        tbl[7] = '{I_NOP,   1'b0, 0, 0, 2, 1, 0, 2'b00, 0, 0};
        tbl[8] = '{I_RTYPE, 1'b1, 3, 0, 7, 1, 1, 2'b00, 0, 0};
        tbl[9] = '{I_LW,    1'b1, 2, 0, 7, 1, 1, 2'b01, 1, 0};

        rst_n = 1'b0;
        start = 1'b1;
        bus.mem_ready = 1'b1;
        setDecode(I_RTYPE, 1'b0);
        #22;
        checkOutput("reset_outputs", {obsVec(), halted, err}, 14'h0);
        checkOutput("reset_count", instr_count, 0);

        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle_busy", busy, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("fetch_after_start", {busy, bus.mem_req, bus.mem_sel}, 3'b110);

        foreach (tbl[i]) applyStimulus(tbl[i], i);

        for (int n = 0; n < 40; n++)
            runModelInstr(iclass_t'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checkOutput("timeout_wait", {bus.mem_req, ir_we, pc_we, err}, 4'b1000);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("timeout_err", {err, busy, bus.mem_req, ir_we}, 4'b1000);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        checkOutput("error_sticky", {err, busy, halted}, 3'b100);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {obsVec(), halted, err}, 14'h0);
        checkOutput("async_reset_count", instr_count, 0);
        modelCount = '0;

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        runModelInstr(I_NOP, 1'b0, 0, 0);
        setDecode(I_NOP, 1'b0);
        opcode = HALT_OPCODE;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("halt_fetch", obsVec(), mk(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0));
        @(negedge clk);
        #1;
        checkOutput("halt_decode", obsVec(), 12'h001);
        @(posedge clk);
        #1;
        checkOutput("halt_state", {halted, busy, err}, 3'b100);
        checkOutput("halt_count", instr_count, modelCount);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b1;
            bus.mem_ready = 1'b1;
            #1;
            checkOutput("halt_ignores_start", {halted, busy, bus.mem_req, ir_we, pc_we, retired}, 6'b100000);
        end
        start = 1'b0;
        checkOutput("halt_count_final", instr_count, modelCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
